// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding and good-measurement constants for the divider monitor
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_MEAS = 2'd2
    } mon_state_e;

    localparam int DEFAULT_N = 3;

    // Posedge sampling of a 50% divided clock sees floor(N/2) highs after the rise sample.
    function automatic int good_high(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/clk_edge_sampler.sv
// rtl/clk_edge_sampler.sv - two-flop sampler of the divided clock with rising-edge detect
module clk_edge_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_in,
    output logic s1,
    output logic rise
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = clk_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign s1   = s1_q;
    assign rise = s1_q & ~s2_q;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures period/high time of a divided clock, tracks lock, flags errors and stuck clocks
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 4 * N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             stuck
);
    localparam int                GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  N_C    = CNT_W'(N);
    localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(good_high(N));
    localparam logic [CNT_W-1:0]  TMO_C  = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_CNT);

    logic s1, rise;

    clk_edge_sampler u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_in (clk_in),
        .s1     (s1),
        .rise   (rise)
    );

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]  hc_q, hc_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              mv_q, mv_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              stuck_q, stuck_d;
    logic              set_err, set_stuck;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hc_d      = hc_q;
        good_d    = good_q;
        period_d  = period_q;
        high_d    = high_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        err_d     = err_q;
        stuck_d   = stuck_q;
        set_err   = 1'b0;
        set_stuck = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_d     = '0;
                hc_d     = '0;
                good_d   = '0;
                locked_d = 1'b0;
                if (en) state_d = ST_SYNC;
            end
            default: begin
                if (!en) begin
                    state_d  = ST_IDLE;
                    pc_d     = '0;
                    hc_d     = '0;
                    good_d   = '0;
                    locked_d = 1'b0;
                end else if (rise) begin
                    pc_d    = CNT_W'(1);
                    hc_d    = '0;
                    state_d = ST_MEAS;
                    // The first rise after SYNC only aligns; the partial period is discarded.
                    if (state_q == ST_MEAS) begin
                        period_d = pc_q;
                        high_d   = hc_q;
                        mv_d     = 1'b1;
                        if (pc_q == N_C && hc_q == HALF_C) begin
                            if (good_q != LOCK_C) good_d = good_q + GOOD_W'(1);
                            locked_d = (good_d == LOCK_C);
                        end else begin
                            good_d   = '0;
                            locked_d = 1'b0;
                            set_err  = 1'b1;
                        end
                    end
                end else if (pc_q == TMO_C) begin
                    pc_d      = '0;
                    hc_d      = '0;
                    good_d    = '0;
                    locked_d  = 1'b0;
                    set_err   = 1'b1;
                    set_stuck = 1'b1;
                    state_d   = ST_SYNC;
                end else begin
                    pc_d = (&pc_q) ? pc_q : pc_q + CNT_W'(1);
                    hc_d = (&hc_q) ? hc_q : hc_q + CNT_W'(s1);
                end
            end
        endcase

        // A set event in the same cycle as clr_err wins.
        if (clr_err) begin
            err_d   = 1'b0;
            stuck_d = 1'b0;
        end
        if (set_err)   err_d   = 1'b1;
        if (set_stuck) stuck_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            hc_q     <= '0;
            good_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            mv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hc_q     <= hc_d;
            good_q   <= good_d;
            period_q <= period_d;
            high_q   <= high_d;
            mv_q     <= mv_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            stuck_q  <= stuck_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign stuck      = stuck_q;

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Single-clock checker for the output of the team's clock dividers. It samples a divided clock (`clk_in`) on the source clock and measures each divided period and high time in source cycles. It declares `locked` after a run of consecutive correct periods, and raises sticky error and stuck flags on deviation or loss of edges. It sits directly downstream of the divider, feeding status/debug logic.

## Interface
- `N`, default 3: expected divide ratio, ≥ 2.
- `CNT_W`, default 8: width of the period and high-time counters, ≥ clog2(TIMEOUT+1).
- `LOCK_CNT`, default 4: consecutive good measurements needed to assert `locked`, ≥ 1.
- `TIMEOUT`, default 4*N: source cycles without a rising edge before `stuck` asserts.

- `clk`  in  1  source clock (same clock that drives the divider); all logic posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  monitor enable.
- `clk_in`  in  1  divided clock under test; synchronous to `clk`, may change on either edge.
- `clr_err`  in  1  one-cycle pulse, clears `err` and `stuck`.
- `period`  out  CNT_W  last measured period in `clk` cycles.
- `high_time`  out  CNT_W  last measured count of high samples.
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_time` update.
- `locked`  out  1  LOCK_CNT consecutive good measurements seen.
- `err`  out  1  sticky: bad measurement or timeout occurred.
- `stuck`  out  1  sticky: timeout occurred.

## Operation
- Sampler: `s1 <= clk_in`, `s2 <= s1`. `rise = s1 & ~s2`. No metastability synchronizer is used, because the input is same-domain.
- States are IDLE, SYNC and MEAS.
  - IDLE when `en=0`. Counters are cleared, `locked=0`, and `period`/`high_time` hold.
  - `en=1` moves IDLE to SYNC.
  - SYNC: the first `rise` moves to MEAS. No measurement is made on this first partial period.
  - MEAS: each `rise` completes one measurement.
- Period counter `pc`: on `rise`, `pc <= 1`; otherwise `pc <= pc+1`, saturating at all-ones.
- High counter `hc`: on `rise`, `hc <= 0`; otherwise `hc <= hc + s1`, saturating.
- On `rise` in MEAS:
  - `period <= pc` and `high_time <= hc`; `meas_valid` pulses.
  - A measurement is good iff `pc == N` and `hc == N/2` (integer division). For odd N with 50% duty the posedge samples see floor(N/2) highs.
  - Good: the good-run counter increments, saturating at LOCK_CNT. `locked` is set when it reaches LOCK_CNT.
  - Bad: the good-run counter is cleared, `locked <= 0` and `err <= 1`.
- Timeout in SYNC or MEAS: when `pc == TIMEOUT` with no `rise`:
  - `stuck <= 1`, `err <= 1`, `locked <= 0`, good-run counter cleared.
  - Next state is SYNC, and `pc` restarts at 0.
- `clr_err` clears `err` and `stuck`. If a set event occurs in the same cycle, the set wins.
- `en` falling in any state returns to IDLE on the next edge. Sticky flags are kept.

## Timing
- Reset values: all outputs 0, state IDLE, `s1`=`s2`=0, all counters 0.
- All outputs are registered.
- Latency: if `clk_in` is high at posedge k, `rise` is true in cycle k→k+1, and `period`/`meas_valid`/`locked` update at posedge k+1.
- `meas_valid` is exactly one cycle wide. Its spacing equals the measured period.
- `locked` rises in the same cycle as the LOCK_CNT-th good `meas_valid`. It falls in the same cycle as a bad `meas_valid`, or on the timeout cycle.
- Reset mid-operation: outputs clear asynchronously on `rst_n` low. On release the block restarts in IDLE.
- Counter saturation: if `pc` saturates, the timeout has already fired, since TIMEOUT < 2^CNT_W.

## Structure
- Shared package/header `clk_div_pkg`: state encodings (IDLE=0, SYNC=1, MEAS=2) and the good-measurement constants (N, N/2).
- One sub-module, `clk_edge_sampler`: the two sampling flops plus `rise` output and registered `s1` level.
- Everything else (FSM, counters, flags) lives in `clk_div_monitor`.

## Test plan
- Drive `clk_in` from the team's odd divider (N=3), `en=1`:
  - `meas_valid` every 3 cycles with `period`=3 and `high_time`=1.
  - `locked`=1 on the 4th `meas_valid`; `err`=0.
- N=5 instance with a 5-divided clock: `period`=5 and `high_time`=2 on every measurement; lock after 4.
- Stretch one `clk_in` period to 4 cycles (N=3):
  - That measurement gives `period`=4; `locked` drops and `err`=1 on the same `meas_valid`.
  - Relock after 4 more good measurements.
- Hold `clk_in` low after lock (N=3, TIMEOUT=12):
  - 12 cycles after the last rise: `stuck`=1, `err`=1, `locked`=0.
  - Resuming the clock gives a first `meas_valid` only after the SYNC rise.
- `clr_err` in the same cycle as a bad measurement: `err` stays 1. `clr_err` alone on the next cycle: `err`=`stuck`=0.
- Assert `rst_n`=0 mid-period: all outputs 0 immediately. Deassert `en` while locked: `locked`=0 next cycle and no further `meas_valid`.
